// File: rtl/dino_score_ctrl.sv
// Game-flow controller for the runner game: start/over sequencing, frame tick,
// high-score tracking and display mux, all in the clk domain.
module dino_score_ctrl #(
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned LOCKOUT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        collision,
  input  logic        disp_sel,
  input  logic [15:0] score_in,
  output logic        game_start,
  output logic        game_over,
  output logic        game_tick,
  output logic [15:0] high_score,
  output logic        new_record,
  output logic [15:0] disp_out,
  output logic [1:0]  state
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LOCK_W  = 8;
  localparam int unsigned SCORE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t              state_q;
  logic                btn_start_q;
  logic [TICK_W-1:0]   tick_cnt;
  logic [LOCK_W-1:0]   lock_cnt;

  logic                start_edge_c;
  logic                start_ok_c;
  logic                tick_wrap_c;
  logic [SCORE_W-1:0]  disp_next_c;

  // Rising edge of the start button; restarts from OVER only once lockout has drained.
  assign start_edge_c = btn_start & ~btn_start_q;
  assign start_ok_c   = start_edge_c &
                        ((state_q == IDLE) || ((state_q == OVER) && (lock_cnt == '0)));
  assign tick_wrap_c  = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Live score while running, otherwise whichever value the player selected.
  assign disp_next_c  = ((state_q != RUN) && disp_sel) ? high_score : score_in;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      btn_start_q <= 1'b0;
      tick_cnt    <= '0;
      lock_cnt    <= '0;
      game_start  <= 1'b0;
      game_over   <= 1'b0;
      game_tick   <= 1'b0;
      high_score  <= '0;
      new_record  <= 1'b0;
      disp_out    <= '0;
    end else begin
      btn_start_q <= btn_start;
      game_start  <= 1'b0;
      game_over   <= 1'b0;
      game_tick   <= 1'b0;
      disp_out    <= disp_next_c;

      // Score settles at the counter one cycle after the game_over pulse.
      if (game_over) begin
        if (score_in > high_score) begin
          high_score <= score_in;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_ok_c) begin
            state_q    <= RUN;
            game_start <= 1'b1;
            tick_cnt   <= '0;
            new_record <= 1'b0;
          end
        end
        RUN: begin
          // Collision wins over a pending tick; start edges are ignored here.
          if (collision) begin
            state_q   <= OVER;
            game_over <= 1'b1;
            tick_cnt  <= '0;
            lock_cnt  <= LOCK_W'(LOCKOUT);
          end else if (tick_wrap_c) begin
            tick_cnt  <= '0;
            game_tick <= 1'b1;
          end else begin
            tick_cnt  <= tick_cnt + 1'b1;
          end
        end
        OVER: begin
          if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - 1'b1;
          end else if (start_ok_c) begin
            state_q    <= RUN;
            game_start <= 1'b1;
            tick_cnt   <= '0;
            new_record <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          tick_cnt <= '0;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dino_score_ctrl.sv
// Bench for dino_score_ctrl: directed scenarios then random traffic, each cycle
// checked against an age/modulo based model of the game rules.
module tb_dino_score_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned LO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic        collision;
  logic        disp_sel;
  logic [15:0] score_in;
  logic        game_start;
  logic        game_over;
  logic        game_tick;
  logic [15:0] high_score;
  logic        new_record;
  logic [15:0] disp_out;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  dino_score_ctrl #(.TICK_DIV(TD), .LOCKOUT(LO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start  (btn_start),
    .collision  (collision),
    .disp_sel   (disp_sel),
    .score_in   (score_in),
    .game_start (game_start),
    .game_over  (game_over),
    .game_tick  (game_tick),
    .high_score (high_score),
    .new_record (new_record),
    .disp_out   (disp_out),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Reference: phase 0 idle, 1 running, 2 over; ages count cycles since the pulses.
  int          m_phase = 0;
  int          run_age = 0;
  int          over_age = 0;
  logic        m_prev = 1'b0;
  logic        m_start = 1'b0;
  logic        m_over = 1'b0;
  logic        m_tick = 1'b0;
  logic        m_rec = 1'b0;
  logic [15:0] m_high = '0;
  logic [15:0] m_disp = '0;

  task automatic model(input logic r, input logic b, input logic c, input logic s,
                       input logic [15:0] sc);
    logic seen;
    logic was_over;
    if (!r) begin
      m_phase = 0; run_age = 0; over_age = 0; m_prev = 1'b0;
      m_start = 1'b0; m_over = 1'b0; m_tick = 1'b0; m_rec = 1'b0;
      m_high = '0; m_disp = '0;
      return;
    end
    seen     = b && !m_prev;
    m_prev   = b;
    was_over = m_over;
    m_disp   = (m_phase != 1 && s) ? m_high : sc;
    m_start  = 1'b0;
    m_over   = 1'b0;
    m_tick   = 1'b0;
    if (was_over) begin
      if (sc > m_high) begin
        m_high = sc;
        m_rec  = 1'b1;
      end else begin
        m_rec = 1'b0;
      end
    end
    case (m_phase)
      0: if (seen) begin
        m_phase = 1; m_start = 1'b1; run_age = 0; m_rec = 1'b0;
      end
      1: begin
        run_age++;
        if (c) begin
          m_phase = 2; m_over = 1'b1; over_age = 0;
        end else if (run_age % TD == 0) begin
          m_tick = 1'b1;
        end
      end
      default: begin
        over_age++;
        if (over_age > LO && seen) begin
          m_phase = 1; m_start = 1'b1; run_age = 0; m_rec = 1'b0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic c, input logic s,
                      input logic [15:0] sc);
    rst_n = r; btn_start = b; collision = c; disp_sel = s; score_in = sc;
    @(posedge clk);
    model(r, b, c, s, sc);
    @(negedge clk);
    chk("game_start", 16'(game_start), 16'(m_start));
    chk("game_over", 16'(game_over), 16'(m_over));
    chk("game_tick", 16'(game_tick), 16'(m_tick));
    chk("high_score", high_score, m_high);
    chk("new_record", 16'(new_record), 16'(m_rec));
    chk("disp_out", disp_out, m_disp);
    chk("state", 16'(state), 16'(m_phase));
    chk("start_over_excl", 16'(game_start & game_over), 16'h0);
    chk("tick_only_run", 16'(game_tick & (state != 2'b01)), 16'h0);
  endtask

  initial begin
    int tick_pos[$];

    // Reset, then idle with the button released.
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_disp", disp_out, 16'h0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

    // Start edge, then ticks at 4, 8, 12 cycles after game_start rises.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0011);
    chk("start_pulse", 16'(game_start), 16'h1);
    chk("run_state", 16'(state), 16'h1);
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'(16'h0020 + i));
      if (game_tick) tick_pos.push_back(i + 1);
    end
    chk("tick_count", 16'(tick_pos.size()), 16'd3);
    if (tick_pos.size() == 3) begin
      chk("tick_1", 16'(tick_pos[0]), 16'd4);
      chk("tick_2", 16'(tick_pos[1]), 16'd8);
      chk("tick_3", 16'(tick_pos[2]), 16'd12);
    end

    // Collision exactly on the cycle a tick would fire.
    for (int i = 0; i < int'(TD) && (run_age % TD) != TD - 1; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0123);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0123);
    chk("over_pulse", 16'(game_over), 16'h1);
    chk("over_no_tick", 16'(game_tick), 16'h0);
    chk("over_state", 16'(state), 16'h2);

    // Start edges during lockout, then held through expiry: no restart.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0123);
    chk("lock_edge1", 16'(state), 16'h2);
    chk("record_set", 16'(new_record), 16'h1);
    chk("high_0123", high_score, 16'h0123);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0999);
    chk("disp_high", disp_out, 16'h0123);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
    chk("lock_edge3", 16'(game_start), 16'h0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
    chk("held_no_restart", 16'(state), 16'h2);

    // Fresh toggle restarts; high score retained, record flag cleared.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0050);
    chk("restart_pulse", 16'(game_start), 16'h1);
    chk("restart_rec_clr", 16'(new_record), 16'h0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0077);
    chk("disp_run", disp_out, 16'h0077);

    // Lower score does not beat the record.
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
    chk("high_kept", high_score, 16'h0123);
    chk("record_clr", 16'(new_record), 16'h0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);

    // Reset mid-run: everything clears with no game_over pulse.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0042);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0042);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0042);
    chk("midrst_state", 16'(state), 16'h0);
    chk("midrst_over", 16'(game_over), 16'h0);
    chk("midrst_high", high_score, 16'h0);

    // Button high at reset release counts as a start edge.
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0042);
    chk("release_start", 16'(game_start), 16'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)),
           16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dino_score_ctrl.md
DINO_SCORE_CTRL -- requirements
Module: dino_score_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 833333: clk cycles per game_tick period (60 Hz at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter LOCKOUT, default 4: clk cycles after game_over during which restart is ignored; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port btn_start, input, 1: start request level, already synchronised to clk.
REQ-006 SHALL have port collision, input, 1: collision level from game logic.
REQ-007 SHALL have port disp_sel, input, 1: display select; 1 shows high score when not running.
REQ-008 SHALL have port score_in, input, 16: current score from the score counter.
REQ-009 SHALL have port game_start, output, 1: one-cycle pulse to the score counter.
REQ-010 SHALL have port game_over, output, 1: one-cycle pulse to the score counter.
REQ-011 SHALL have port game_tick, output, 1: one-cycle frame pulse while running.
REQ-012 SHALL have port high_score, output, 16: best score since reset.
REQ-013 SHALL have port new_record, output, 1: last finished game set a new high score.
REQ-014 SHALL have port disp_out, output, 16: registered display value.
REQ-015 SHALL have port state, output, 2: IDLE=00, RUN=01, OVER=10; 11 unused.

Function
REQ-016 SHALL register btn_start one cycle; start edge = btn_start & ~btn_start_q.
REQ-017 SHALL, in IDLE, on a start edge at edge N: state=RUN, game_start=1 for exactly cycle N..N+1, tick counter=0.
REQ-018 SHALL, in RUN, increment a tick counter 0..TICK_DIV-1 and wrap; game_tick=1 for one cycle after the counter value TICK_DIV-1 is registered, so first tick is TICK_DIV cycles after game_start rises.
REQ-019 SHALL, in RUN with collision=1: state=OVER, game_over=1 for one cycle, tick counter cleared, no game_tick issued that cycle.
REQ-020 SHALL give collision priority over a start edge and over a tick in the same cycle.
REQ-021 SHALL ignore start edges in RUN.
REQ-022 SHALL, one cycle after game_over is high, compare score_in unsigned against high_score; if greater, load high_score=score_in and set new_record=1; if equal or less, new_record=0.
REQ-023 SHALL hold new_record until the next game_start pulse, which clears it.
REQ-024 SHALL, on entry to OVER, load a lockout counter with LOCKOUT and decrement it to 0; start edges while it is nonzero are dropped, not queued.
REQ-025 SHALL, in OVER with lockout 0, on a start edge: state=RUN, game_start pulse, tick counter=0; high_score retained.
REQ-026 SHALL, if btn_start is held high through lockout expiry, not restart; a fresh 0->1 transition is required.
REQ-027 SHALL set disp_out to score_in in RUN, and in IDLE/OVER to high_score if disp_sel=1 else score_in, registered one cycle.
REQ-028 SHALL never assert game_start and game_over in the same cycle, and never assert game_tick outside RUN.
REQ-029 SHALL return from the unused state 11 to IDLE on the next edge with all pulses low.

Reset
REQ-030 SHALL, with rst_n=0 at a clk edge, set state=IDLE, game_start=game_over=game_tick=0, high_score=0, new_record=0, disp_out=0, tick counter=0, lockout=0, btn_start_q=0.
REQ-031 SHALL give reset priority over all other inputs; reset mid-RUN emits no game_over pulse.
REQ-032 SHALL treat btn_start high at reset release as a start edge on the first cycle after release (btn_start_q was 0).

Verification (TICK_DIV=4, LOCKOUT=3)
REQ-033 SHALL cover: reset, btn_start 0->1 -> game_start one cycle, state=01, game_tick at 4, 8, 12 cycles after game_start rise.
REQ-034 SHALL cover: RUN, collision=1 on same cycle as tick would fire -> game_over one cycle, no game_tick, state=10.
REQ-035 SHALL cover: score_in=0x0123 at game over with high_score=0 -> high_score=0x0123, new_record=1; next game ends with 0x0100 -> high_score stays 0x0123, new_record=0.
REQ-036 SHALL cover: start edge 1 and 2 cycles after game_over -> ignored; edge after 3 cycles, btn_start held 1 through lockout -> no restart until toggled.
REQ-037 SHALL cover: disp_sel=1 in OVER -> disp_out=high_score one cycle later; disp_sel=1 in RUN -> disp_out=score_in.
REQ-038 SHALL cover: rst_n=0 mid-RUN -> next cycle all outputs 0, state=00, no game_over pulse.
